// File: rtl/uart_tx_capture_if.sv
// Byte handshake between the UART capture FIFO and its consumer.
// The capture block drives data/valid; the consumer drives ready.
interface uart_tx_capture_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;

  modport master (output rx_data, output rx_valid, input rx_ready);
  modport slave  (input rx_data, input rx_valid, output rx_ready);
endinterface

// File: rtl/uart_tx_capture.sv
// 8N1 receiver for the processor console TX line.
// Decoded bytes go into a small FIFO that is drained over a valid/ready port.
module uart_tx_capture #(
  parameter int BAUD_DIV   = 87,
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = 4
) (
  input  logic             sysclk,
  input  logic             nsysreset,
  input  logic             rx_in,
  uart_tx_capture_if.master rx,
  output logic             framing_err,
  output logic             overflow,
  input  logic             clr_overflow,
  output logic [CNT_W-1:0] fifo_count
);
  localparam int TW = 16;
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [TW-1:0] MID  = TW'(BAUD_DIV / 2);
  localparam logic [TW-1:0] LAST = TW'(BAUD_DIV - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_t;

  state_t          state;
  logic [TW-1:0]   cnt;
  logic [2:0]      bit_idx;
  logic [7:0]      shreg;
  logic            rx_meta, rx_s;

  logic [7:0]      mem [FIFO_DEPTH];
  logic [AW-1:0]   wptr, rptr;
  logic            push, pop, wr, full;

  // Line is idle-high, so the synchroniser presets to 1 to avoid a false start.
  always_ff @(posedge sysclk or negedge nsysreset) begin
    if (!nsysreset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx_in;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge sysclk or negedge nsysreset) begin
    if (!nsysreset) begin
      state       <= IDLE;
      cnt         <= '0;
      bit_idx     <= '0;
      shreg       <= '0;
      framing_err <= 1'b0;
    end else begin
      framing_err <= 1'b0;
      cnt         <= cnt + 1'b1;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (!rx_s) state <= START;
        end
        START: begin
          if (cnt == MID) begin
            cnt <= '0;
            if (!rx_s) begin
              state   <= DATA;
              bit_idx <= '0;
            end else begin
              state <= IDLE;
            end
          end
        end
        DATA: begin
          if (cnt == LAST) begin
            cnt     <= '0;
            shreg   <= {rx_s, shreg[7:1]};
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == 3'd7) state <= STOP;
          end
        end
        STOP: begin
          if (cnt == LAST) begin
            cnt <= '0;
            if (rx_s) begin
              state <= IDLE;
            end else begin
              framing_err <= 1'b1;
              state       <= WAIT_IDLE;
            end
          end
        end
        WAIT_IDLE: begin
          cnt <= '0;
          if (rx_s) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Push lands on the stop-bit sample edge itself so valid rises one cycle later.
  assign push = (state == STOP) && (cnt == LAST) && rx_s;
  assign full = (fifo_count == CNT_W'(FIFO_DEPTH));
  assign pop  = rx.rx_valid & rx.rx_ready;
  assign wr   = push & (~full | pop);

  always_ff @(posedge sysclk) begin
    if (wr) mem[wptr] <= shreg;
  end

  always_ff @(posedge sysclk or negedge nsysreset) begin
    if (!nsysreset) begin
      wptr       <= '0;
      rptr       <= '0;
      fifo_count <= '0;
      overflow   <= 1'b0;
    end else begin
      if (wr)  wptr <= wptr + 1'b1;
      if (pop) rptr <= rptr + 1'b1;
      case ({wr, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
      // A new overflow wins over a same-cycle clear.
      if (push && full && !pop) overflow <= 1'b1;
      else if (clr_overflow)    overflow <= 1'b0;
    end
  end

  assign rx.rx_valid = (fifo_count != '0);
  assign rx.rx_data  = rx.rx_valid ? mem[rptr] : 8'h00;
endmodule

// File: tb/tb_uart_tx_capture.sv
// Scoreboard bench for uart_tx_capture: stimulus queues expected bytes,
// a negedge monitor pops and compares on every accepted handshake.
module tb_uart_tx_capture;
  localparam int BAUD  = 16;
  localparam int DEPTH = 4;
  localparam int CW    = 3;

  logic          sysclk = 1'b0;
  logic          nsysreset = 1'b0;
  logic          rx_in = 1'b1;
  logic          clr_overflow = 1'b0;
  logic          framing_err, overflow;
  logic [CW-1:0] fifo_count;

  uart_tx_capture_if rx ();

  uart_tx_capture #(.BAUD_DIV(BAUD), .FIFO_DEPTH(DEPTH), .CNT_W(CW)) dut (
    .sysclk       (sysclk),
    .nsysreset    (nsysreset),
    .rx_in        (rx_in),
    .rx           (rx),
    .framing_err  (framing_err),
    .overflow     (overflow),
    .clr_overflow (clr_overflow),
    .fifo_count   (fifo_count)
  );

  always #5 sysclk = ~sysclk;

  int         checks = 0;
  int         errors = 0;
  int         fe_seen = 0;
  logic [7:0] exp_q [$];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge sysclk);
      #1;
    end
  endtask

  task automatic send(input logic [7:0] d, input logic stop);
    rx_in = 1'b0;
    tick(BAUD);
    for (int i = 0; i < 8; i++) begin
      rx_in = d[i];
      tick(BAUD);
    end
    rx_in = stop;
    tick(BAUD);
    rx_in = 1'b1;
    tick(2 * BAUD);
  endtask

  task automatic wait_empty(input string name);
    int n;
    n = 0;
    while (fifo_count != 0 && n < 2000) begin
      tick(1);
      n++;
    end
    check(name, int'(fifo_count), 0);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_rx_valid"}, int'(rx.rx_valid), 0);
    check({tag, "_rx_data"}, int'(rx.rx_data), 0);
    check({tag, "_framing_err"}, int'(framing_err), 0);
    check({tag, "_overflow"}, int'(overflow), 0);
    check({tag, "_fifo_count"}, int'(fifo_count), 0);
  endtask

  // Monitor: compares every byte the consumer accepts against the scoreboard.
  initial begin
    logic [7:0] e;
    forever begin
      @(negedge sysclk);
      if (nsysreset) begin
        if (framing_err) fe_seen++;
        if (rx.rx_valid && rx.rx_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_byte actual=%0h expected=none", rx.rx_data);
          end else begin
            e = exp_q.pop_front();
            check("rx_data", int'(rx.rx_data), int'(e));
          end
        end
      end
    end
  end

  initial begin
    rx.rx_ready = 1'b0;
    tick(3);
    check_reset_vals("reset");
    nsysreset = 1'b1;
    tick(3);

    // 1: two good bytes, consumer always ready
    rx.rx_ready = 1'b1;
    exp_q.push_back(8'h55);
    exp_q.push_back(8'hA3);
    send(8'h55, 1'b1);
    send(8'hA3, 1'b1);
    tick(4);
    check("t1_queue_left", exp_q.size(), 0);
    check("t1_framing", fe_seen, 0);

    // 2: short glitch must not start a frame
    rx_in = 1'b0;
    tick(6);
    rx_in = 1'b1;
    tick(3 * BAUD);
    check("t2_count", int'(fifo_count), 0);
    check("t2_framing", fe_seen, 0);

    // 3: bad stop bit, then a good byte
    send(8'h3C, 1'b0);
    check("t3_framing", fe_seen, 1);
    check("t3_count", int'(fifo_count), 0);
    exp_q.push_back(8'h7E);
    send(8'h7E, 1'b1);
    tick(4);
    check("t3_queue_left", exp_q.size(), 0);

    // 4: overflow with consumer stalled
    rx.rx_ready = 1'b0;
    for (int b = 1; b <= 4; b++) exp_q.push_back(8'(b));
    for (int b = 1; b <= 5; b++) send(8'(b), 1'b1);
    check("t4_count", int'(fifo_count), 4);
    check("t4_overflow", int'(overflow), 1);
    rx.rx_ready = 1'b1;
    wait_empty("t4_drain");
    check("t4_overflow_sticky", int'(overflow), 1);
    clr_overflow = 1'b1;
    tick(1);
    clr_overflow = 1'b0;
    check("t4_overflow_clr", int'(overflow), 0);
    check("t4_queue_left", exp_q.size(), 0);

    // 5: pop coincides with the stop-bit push into a full FIFO
    rx.rx_ready = 1'b0;
    exp_q.push_back(8'h11);
    exp_q.push_back(8'h22);
    exp_q.push_back(8'h33);
    exp_q.push_back(8'h44);
    exp_q.push_back(8'h99);
    send(8'h11, 1'b1);
    send(8'h22, 1'b1);
    send(8'h33, 1'b1);
    send(8'h44, 1'b1);
    check("t5_full", int'(fifo_count), 4);
    rx_in = 1'b0;
    tick(BAUD);
    for (int i = 0; i < 8; i++) begin
      rx_in = (8'h99 >> i) & 1'b1;
      tick(BAUD);
    end
    rx_in = 1'b1;
    tick(11);
    rx.rx_ready = 1'b1;
    tick(1);
    rx.rx_ready = 1'b0;
    check("t5_count", int'(fifo_count), 4);
    check("t5_overflow", int'(overflow), 0);
    tick(2 * BAUD);
    rx.rx_ready = 1'b1;
    wait_empty("t5_drain");
    check("t5_queue_left", exp_q.size(), 0);

    // 6: reset during bit 4 of 0xF0, then 0x81
    rx_in = 1'b0;
    tick(BAUD);
    for (int i = 0; i < 4; i++) begin
      rx_in = 1'b0;
      tick(BAUD);
    end
    rx_in = 1'b1;
    tick(BAUD / 2);
    nsysreset = 1'b0;
    tick(3);
    check_reset_vals("t6_reset");
    nsysreset = 1'b1;
    tick(4 * BAUD);
    exp_q.push_back(8'h81);
    send(8'h81, 1'b1);
    tick(4);
    check("t6_queue_left", exp_q.size(), 0);
    check("t6_framing", fe_seen, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
